floating_point_addsub_pipelined: RTL and testbench

Parametrised, fully pipelined IEEE-754 binary floating-point adder/subtractor. It is the clocked successor of the combinational addition datapath. It keeps the five-stage split (exponent compare/swap, mantissa align, mantissa add/sub, normalise, round/pack) and registers each stage. It adds a valid/ready handshake with backpressure, guard/round/sticky rounding, special-value handling and exception flags. It sits between the FPU operand issue logic and the FPU result writeback.

---
 rtl/floating_point_addsub_pipelined.sv | 221 ++++++++++++++++++++++
 tb/tb_floating_point_addsub_pipelined.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_addsub_pipelined.sv
// Five-stage pipelined IEEE-754 adder/subtractor with valid/ready handshake, global stall and GRS rounding.
// Optional FPU_ROUND_MODE_EN adds round_mode_in (RNE/RTZ/RUP/RDN); otherwise rounding is fixed RNE.
module floating_point_addsub_pipelined #(
   parameter int EXPO_WIDTH = 8,
   parameter int MENT_WIDTH = 23,
   parameter int DATA_WIDTH = 1 + EXPO_WIDTH + MENT_WIDTH
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
`ifdef FPU_ROUND_MODE_EN
   input  logic [1:0]            round_mode_in,
`endif
   input  logic                  in_valid_in,
   output logic                  in_ready_out,
   input  logic [DATA_WIDTH-1:0] floating1_in,
   input  logic [DATA_WIDTH-1:0] floating2_in,
   input  logic                  opcode_in,
   output logic                  out_valid_out,
   input  logic                  out_ready_in,
   output logic [DATA_WIDTH-1:0] floating_result_out,
   output logic [3:0]            flags_out
);

   localparam int AW  = MENT_WIDTH + 4;
   localparam int SW  = MENT_WIDTH + 5;
   localparam int LZW = $clog2(AW + 1);
   localparam int XW  = EXPO_WIDTH + 2;
   localparam logic [DATA_WIDTH-1:0] QNAN =
      {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MENT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RUP, RM_RDN} round_mode_t;

   // Per-operation side band: rounding mode and any special-value override.
   typedef struct packed {
      round_mode_t           rm;
      logic                  spec;
      logic [3:0]            flags;
      logic [DATA_WIDTH-1:0] res;
   } ctl_t;

   logic advance;
   assign advance      = ~out_valid_out | out_ready_in;
   assign in_ready_out = advance;

   round_mode_t rm_c;
`ifdef FPU_ROUND_MODE_EN
   assign rm_c = round_mode_t'(round_mode_in);
`else
   assign rm_c = RM_RNE;
`endif

   logic                  sign_a, sign_b, zero_a, zero_b, nan_a, nan_b, inf_a, inf_b, snan_a, snan_b, swap;
   logic [EXPO_WIDTH-1:0] exp_a, exp_b;
   logic [MENT_WIDTH-1:0] man_a, man_b;
   ctl_t                  ctl_c;

   always_comb begin
      sign_a = floating1_in[DATA_WIDTH-1];
      sign_b = floating2_in[DATA_WIDTH-1] ^ opcode_in;
      exp_a  = floating1_in[DATA_WIDTH-2:MENT_WIDTH];
      exp_b  = floating2_in[DATA_WIDTH-2:MENT_WIDTH];
      zero_a = (exp_a == '0);
      zero_b = (exp_b == '0);
      nan_a  = (&exp_a) & (|floating1_in[MENT_WIDTH-1:0]);
      nan_b  = (&exp_b) & (|floating2_in[MENT_WIDTH-1:0]);
      inf_a  = (&exp_a) & ~(|floating1_in[MENT_WIDTH-1:0]);
      inf_b  = (&exp_b) & ~(|floating2_in[MENT_WIDTH-1:0]);
      snan_a = nan_a & ~floating1_in[MENT_WIDTH-1];
      snan_b = nan_b & ~floating2_in[MENT_WIDTH-1];
      man_a  = zero_a ? '0 : floating1_in[MENT_WIDTH-1:0];
      man_b  = zero_b ? '0 : floating2_in[MENT_WIDTH-1:0];
      swap   = {exp_b, man_b} > {exp_a, man_a};
      ctl_c       = '0;
      ctl_c.rm    = rm_c;
      ctl_c.spec  = 1'b1;
      if (nan_a | nan_b) begin
         ctl_c.res   = QNAN;
         ctl_c.flags = {snan_a | snan_b, 3'b000};
      end else if (inf_a & inf_b & (sign_a != sign_b)) begin
         ctl_c.res   = QNAN;
         ctl_c.flags = 4'b1000;
      end else if (inf_a) begin
         ctl_c.res = {sign_a, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
      end else if (inf_b) begin
         ctl_c.res = {sign_b, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
      end else if (zero_a & zero_b) begin
         ctl_c.res = {(rm_c == RM_RDN) ? (sign_a | sign_b) : (sign_a & sign_b),
                      {(DATA_WIDTH-1){1'b0}}};
      end else begin
         ctl_c.spec = 1'b0;
      end
   end

   logic                  s1_valid, s2_valid, s3_valid, s4_valid;
   ctl_t                  s1_ctl, s2_ctl, s3_ctl, s4_ctl;
   logic                  s1_sign_big, s1_sign_small, s2_sign, s2_sub, s3_sign, s4_sign, s4_zero;
   logic [EXPO_WIDTH-1:0] s1_exp_big, s2_exp, s3_exp;
   logic [EXPO_WIDTH:0]   s1_exp_diff;
   logic [MENT_WIDTH:0]   s1_man_big, s1_man_small;
   logic [AW-1:0]         s2_big, s2_small, s4_man;
   logic [SW-1:0]         s3_sum;
   logic [XW-1:0]         s4_exp;

   logic [AW-1:0]  small_ext, small_shift, small_al;
   always_comb begin
      small_ext   = {s1_man_small, 3'b000};
      small_shift = small_ext >> s1_exp_diff;
      if (s1_exp_diff >= (EXPO_WIDTH+1)'(AW - 1))
         small_al = {{(AW-1){1'b0}}, |s1_man_small};
      else
         small_al = {small_shift[AW-1:1],
                     small_shift[0] | (|(small_ext & ~({AW{1'b1}} << s1_exp_diff)))};
   end

   logic [SW-1:0]  sum_c;
   assign sum_c = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                         : ({1'b0, s2_big} + {1'b0, s2_small});

   logic [LZW-1:0] lz;
   logic [AW-1:0]  norm_c;
   logic [XW-1:0]  norm_exp_c;
   always_comb begin
      lz = '0;
      for (int unsigned i = 0; i < AW; i++)
         if (s3_sum[i]) lz = LZW'(AW - 1 - i);
      if (s3_sum[SW-1]) begin
         norm_c     = {s3_sum[SW-1:2], s3_sum[1] | s3_sum[0]};
         norm_exp_c = {2'b00, s3_exp} + XW'(1);
      end else begin
         norm_c     = s3_sum[AW-1:0] << lz;
         norm_exp_c = {2'b00, s3_exp} - XW'(lz);
      end
   end

   logic                  inexact, inc, ovf_max;
   logic [MENT_WIDTH+1:0] rnd;
   logic [XW-1:0]         exp_r;
   logic [MENT_WIDTH-1:0] frac;
   logic [DATA_WIDTH-1:0] res_c;
   logic [3:0]            flags_c;
   always_comb begin
      inexact = |s4_man[2:0];
      unique case (s4_ctl.rm)
         RM_RNE: inc = s4_man[2] & (s4_man[1] | s4_man[0] | s4_man[3]);
         RM_RTZ: inc = 1'b0;
         RM_RUP: inc = ~s4_sign & inexact;
         RM_RDN: inc = s4_sign & inexact;
      endcase
      rnd     = {1'b0, s4_man[AW-1:3]} + (MENT_WIDTH+2)'(inc);
      exp_r   = s4_exp + XW'(rnd[MENT_WIDTH+1]);
      frac    = rnd[MENT_WIDTH+1] ? rnd[MENT_WIDTH:1] : rnd[MENT_WIDTH-1:0];
      ovf_max = (s4_ctl.rm == RM_RTZ) | ((s4_ctl.rm == RM_RUP) & s4_sign) |
                ((s4_ctl.rm == RM_RDN) & ~s4_sign);
      res_c   = {s4_sign, exp_r[EXPO_WIDTH-1:0], frac};
      flags_c = {3'b000, inexact};
      if (s4_ctl.spec) begin
         res_c   = s4_ctl.res;
         flags_c = s4_ctl.flags;
      end else if (s4_zero) begin
         res_c   = {s4_ctl.rm == RM_RDN, {(DATA_WIDTH-1){1'b0}}};
         flags_c = '0;
      end else if (!exp_r[XW-1] && exp_r[XW-2:0] >= (XW-1)'(2**EXPO_WIDTH - 1)) begin
         res_c   = ovf_max ? {s4_sign, (EXPO_WIDTH)'(2**EXPO_WIDTH - 2), {MENT_WIDTH{1'b1}}}
                           : {s4_sign, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
         flags_c = 4'b0101;
      end else if (exp_r[XW-1] || exp_r == '0) begin
         res_c   = {s4_sign, {(DATA_WIDTH-1){1'b0}}};
         flags_c = 4'b0011;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid            <= 1'b0;
         s2_valid            <= 1'b0;
         s3_valid            <= 1'b0;
         s4_valid            <= 1'b0;
         out_valid_out       <= 1'b0;
         floating_result_out <= '0;
         flags_out           <= '0;
      end else if (advance) begin
         s1_valid      <= in_valid_in;
         s2_valid      <= s1_valid;
         s3_valid      <= s2_valid;
         s4_valid      <= s3_valid;
         out_valid_out <= s4_valid;
         if (s4_valid) begin
            floating_result_out <= res_c;
            flags_out           <= flags_c;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (advance) begin
         s1_ctl        <= ctl_c;
         s1_sign_big   <= swap ? sign_b : sign_a;
         s1_sign_small <= swap ? sign_a : sign_b;
         s1_exp_big    <= swap ? exp_b : exp_a;
         s1_exp_diff   <= swap ? ({1'b0, exp_b} - {1'b0, exp_a}) : ({1'b0, exp_a} - {1'b0, exp_b});
         s1_man_big    <= swap ? {~zero_b, man_b} : {~zero_a, man_a};
         s1_man_small  <= swap ? {~zero_a, man_a} : {~zero_b, man_b};
         s2_ctl        <= s1_ctl;
         s2_sign       <= s1_sign_big;
         s2_sub        <= s1_sign_big ^ s1_sign_small;
         s2_exp        <= s1_exp_big;
         s2_big        <= {s1_man_big, 3'b000};
         s2_small      <= small_al;
         s3_ctl        <= s2_ctl;
         s3_sign       <= s2_sign;
         s3_exp        <= s2_exp;
         s3_sum        <= sum_c;
         s4_ctl        <= s3_ctl;
         s4_sign       <= s3_sign;
         s4_zero       <= ~(|s3_sum);
         s4_exp        <= norm_exp_c;
         s4_man        <= norm_c;
      end
   end

endmodule

// File: tb/tb_floating_point_addsub_pipelined.sv
// Scoreboard bench for floating_point_addsub_pipelined: latency, rounding, specials, backpressure, async reset.
module tb_floating_point_addsub_pipelined;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, opcode, out_valid, out_ready;
   logic [31:0] a, b, res;
   logic [3:0]  flags;

   always #5 clk = ~clk;

   floating_point_addsub_pipelined #(.EXPO_WIDTH(8), .MENT_WIDTH(23), .DATA_WIDTH(32)) dut (
      .clk_in(clk), .rst_in(rst), .in_valid_in(in_valid), .in_ready_out(in_ready),
      .floating1_in(a), .floating2_in(b), .opcode_in(opcode),
      .out_valid_out(out_valid), .out_ready_in(out_ready),
      .floating_result_out(res), .flags_out(flags)
   );

   typedef struct packed { logic [31:0] r; logic [3:0] f; } exp_t;
   typedef struct { logic [31:0] a; logic [31:0] b; logic op; exp_t e; } stim_t;

   stim_t pend[$];
   exp_t  sb[$];
   int    total = 0;
   int    bad   = 0;

   task automatic push_op(input logic [31:0] oa, input logic [31:0] ob, input logic op,
                          input logic [31:0] r, input logic [3:0] f);
      stim_t s;
      s.a = oa; s.b = ob; s.op = op; s.e.r = r; s.e.f = f;
      pend.push_back(s);
   endtask

   // Called just after a falling edge; decides what the next rising edge will accept/transfer.
   task automatic drive_cycle(input logic rdy, output logic acc, output logic xfer);
      out_ready = rdy;
      if (pend.size() > 0) begin
         in_valid = 1'b1; a = pend[0].a; b = pend[0].b; opcode = pend[0].op;
      end else begin
         in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
         sb.push_back(pend[0].e);
         pend.delete(0);
      end
      xfer = out_valid && out_ready;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opcode = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (res !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=00000000", res); end
      total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_latency();
      logic acc, xfer;
      int   lat;
      exp_t e;
      push_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
      drive_cycle(1'b1, acc, xfer);
      total++; if (!acc) begin bad++; $display("FAIL lat_accept got=%b exp=1", acc); end
      lat = 0; xfer = 1'b0;
      while (!xfer && lat < 20) begin
         @(negedge clk); lat++;
         drive_cycle(1'b1, acc, xfer);
      end
      total++; if (lat != 5) begin bad++; $display("FAIL lat_cycles got=%0d exp=5", lat); end
      if (xfer && sb.size() > 0) begin
         e = sb.pop_front();
         total++; if (res !== e.r) begin bad++; $display("FAIL lat_result got=%h exp=%h", res, e.r); end
         total++; if (flags !== e.f) begin bad++; $display("FAIL lat_flags got=%b exp=%b", flags, e.f); end
      end
      @(negedge clk);
   endtask

   task automatic test_specials();
      logic acc, xfer;
      int   got, cyc, n;
      exp_t e;
      push_op(32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000); // 3-3
      push_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000); // -0 + -0
      push_op(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000); // +0 + -0
      push_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001); // tie, even
      push_op(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001); // tie, odd
      push_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101); // overflow
      push_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000); // inf-inf
      push_op(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000); // sNaN
      push_op(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000); // qNaN
      push_op(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000); // -inf + 1
      push_op(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000); // subnormal flushed
      push_op(32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 4'b0001); // round carry
      push_op(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001); // above half
      push_op(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011); // underflow
      push_op(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000); // 1-2
      push_op(32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 4'b0000); // -3+1
      n = pend.size(); got = 0; cyc = 0;
      while (got < n && cyc < 200) begin
         drive_cycle(1'b1, acc, xfer);
         if (xfer) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL spec_extra got=%h exp=none", res);
            end else begin
               e = sb.pop_front();
               if (res !== e.r || flags !== e.f) begin
                  bad++; $display("FAIL spec_op%0d got=%h/%b exp=%h/%b", got, res, flags, e.r, e.f);
               end
            end
            got++;
         end
         @(negedge clk); cyc++;
      end
      total++; if (got != n) begin bad++; $display("FAIL spec_count got=%0d exp=%0d", got, n); end
   endtask

   task automatic test_back_to_back();
      logic        acc, xfer, rdy, held;
      logic [31:0] held_r;
      logic [3:0]  held_f;
      int          got, cyc, stalls;
      exp_t        e;
      push_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
      push_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
      push_op(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
      push_op(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
      push_op(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000);
      push_op(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 4'b0000);
      push_op(32'h3F000000, 32'h3F000000, 1'b0, 32'h3F800000, 4'b0000);
      push_op(32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 4'b0000);
      got = 0; cyc = 0; stalls = 0; held = 1'b0; held_r = '0; held_f = '0;
      while (got < 8 && cyc < 100) begin
         rdy = !(cyc >= 7 && cyc <= 9);
         drive_cycle(rdy, acc, xfer);
         total++;
         if (in_ready !== (!out_valid || rdy)) begin
            bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !out_valid || rdy);
         end
         if (!in_ready) stalls++;
         if (held) begin
            total++;
            if (out_valid !== 1'b1 || res !== held_r || flags !== held_f) begin
               bad++; $display("FAIL b2b_hold cyc=%0d got=%h exp=%h", cyc, res, held_r);
            end
         end
         held = out_valid && !rdy; held_r = res; held_f = flags;
         if (xfer) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL b2b_extra got=%h exp=none", res);
            end else begin
               e = sb.pop_front();
               if (res !== e.r || flags !== e.f) begin
                  bad++; $display("FAIL b2b_op%0d got=%h/%b exp=%h/%b", got, res, flags, e.r, e.f);
               end
            end
            got++;
         end
         @(negedge clk); cyc++;
      end
      total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", got); end
      total++; if (stalls != 3) begin bad++; $display("FAIL b2b_stalls got=%0d exp=3", stalls); end
      repeat (3) begin
         drive_cycle(1'b1, acc, xfer);
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_dup got=%h exp=idle", res); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_inflight();
      logic acc, xfer;
      int   cyc, stale, got;
      exp_t e;
      push_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
      push_op(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
      push_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
      cyc = 0;
      do begin
         drive_cycle(1'b0, acc, xfer);
         @(negedge clk); cyc++;
      end while (!out_valid && cyc < 20);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
      #2 rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
      total++; if (res !== 32'h0) begin bad++; $display("FAIL rst_async_result got=%h exp=00000000", res); end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sb.delete();
      pend.delete();
      stale = 0;
      repeat (8) begin
         drive_cycle(1'b1, acc, xfer);
         if (out_valid) stale++;
         @(negedge clk);
      end
      total++; if (stale != 0) begin bad++; $display("FAIL rst_stale got=%0d exp=0", stale); end
      push_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
      got = 0; cyc = 0;
      while (got < 1 && cyc < 20) begin
         drive_cycle(1'b1, acc, xfer);
         if (xfer) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL rst_new_extra got=%h exp=none", res);
            end else begin
               e = sb.pop_front();
               if (res !== e.r || flags !== e.f) begin
                  bad++; $display("FAIL rst_new got=%h/%b exp=%h/%b", res, flags, e.r, e.f);
               end
            end
            got++;
         end
         @(negedge clk); cyc++;
      end
      total++; if (got != 1) begin bad++; $display("FAIL rst_new_count got=%0d exp=1", got); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_specials();
      test_back_to_back();
      test_reset_inflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
